// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter: a WIDTH-bit word accepted over valid/ready
// is shifted out one bit per clock, with per-bit valid and a last-bit marker.
module piso_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    output logic             sout,
    output logic             sout_valid,
    output logic             sout_last,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   sreg_q, sreg_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               accept;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path
        // through the case leaves it unassigned, which would infer a latch.
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        accept  = load_valid && load_ready;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SHIFT;
                    sreg_d  = load_data;
                    cnt_d   = CNT_LAST;
                end
            end
            SHIFT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                    if (MSB_FIRST) sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
                    else           sreg_d = {1'b0, sreg_q[WIDTH-1:1]};
                end else if (accept) begin
                    // Last bit goes out while the next word loads: zero-gap frames.
                    sreg_d = load_data;
                    cnt_d  = CNT_LAST;
                end else begin
                    state_d = IDLE;
                    sreg_d  = '0;
                end
            end
            default: begin
                state_d = IDLE;
                sreg_d  = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        load_ready = !rst && ((state_q == IDLE) || (cnt_q == '0));
        sout_valid = (state_q == SHIFT);
        busy       = sout_valid;
        sout_last  = sout_valid && (cnt_q == '0);
        if (!sout_valid) sout = 1'b0;
        else if (MSB_FIRST) sout = sreg_q[WIDTH-1];
        else sout = sreg_q[0];
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for piso_serializer: an MSB-first and an LSB-first instance,
// hand-written bit sequences queued by stimulus and popped by a negedge monitor.
module tb_piso_serializer;

    typedef struct packed {
        logic bit_v;
        logic last_v;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       lv_m, lv_l;
    logic [7:0] ld_m, ld_l;
    logic       rdy_m, sout_m, sval_m, slast_m, busy_m;
    logic       rdy_l, sout_l, sval_l, slast_l, busy_l;

    exp_t exp_m[$];
    exp_t exp_l[$];
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst(rst), .load_valid(lv_m), .load_ready(rdy_m), .load_data(ld_m),
        .sout(sout_m), .sout_valid(sval_m), .sout_last(slast_m), .busy(busy_m)
    );

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst(rst), .load_valid(lv_l), .load_ready(rdy_l), .load_data(ld_l),
        .sout(sout_l), .sout_valid(sval_l), .sout_last(slast_l), .busy(busy_l)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Queue bits in the order written (bits[n-1] goes out first).
    task automatic push_seq(input bit sel, input logic [15:0] bits, input int n, input bit ends_frame);
        exp_t e;
        for (int i = n - 1; i >= 0; i--) begin
            e.bit_v  = bits[i];
            e.last_v = ends_frame && (i == 0);
            if (sel) exp_l.push_back(e);
            else     exp_m.push_back(e);
        end
    endtask

    // Walk n frame cycles; load_ready must be high only on the ready_at-th one.
    task automatic watch(input bit sel, input int n, input int ready_at);
        for (int i = 1; i <= n; i++) begin
            check(sel ? "l_valid" : "m_valid", sel ? sval_l : sval_m, 1);
            check(sel ? "l_busy"  : "m_busy",  sel ? busy_l : busy_m, 1);
            check(sel ? "l_ready" : "m_ready", sel ? rdy_l : rdy_m, (i == ready_at) ? 1 : 0);
            tick();
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sval_m) begin
            if (exp_m.size() == 0) check("m_extra_bit", sval_m, 0);
            else begin
                e = exp_m.pop_front();
                check("m_sout", sout_m, e.bit_v);
                check("m_last", slast_m, e.last_v);
            end
        end else check("m_last_idle", slast_m, 0);
        if (sval_l) begin
            if (exp_l.size() == 0) check("l_extra_bit", sval_l, 0);
            else begin
                e = exp_l.pop_front();
                check("l_sout", sout_l, e.bit_v);
                check("l_last", slast_l, e.last_v);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required finish before 100000");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; lv_m = 1'b1; ld_m = 8'hFF; lv_l = 1'b0; ld_l = 8'h00;
        #1;
        check("ready_in_reset", rdy_m, 0);
        tick();
        tick();
        check("reset_valid", sval_m, 0);
        check("reset_sout", sout_m, 0);
        rst = 1'b0; lv_m = 1'b0;
        #1;
        check("idle_ready", rdy_m, 1);
        check("idle_valid", sval_m, 0);
        check("idle_last", slast_m, 0);
        check("idle_busy", busy_m, 0);
        check("idle_l_ready", rdy_l, 1);

        // Single MSB-first frame 0x0F
        push_seq(0, 16'b0000_1111, 8, 1);
        lv_m = 1'b1; ld_m = 8'h0F;
        tick();
        lv_m = 1'b0; ld_m = 8'h55;
        watch(0, 8, 8);
        check("single_idle_after", sval_m, 0);

        // LSB-first frame 0xC1
        push_seq(1, 16'b1000_0011, 8, 1);
        lv_l = 1'b1; ld_l = 8'hC1;
        tick();
        lv_l = 1'b0;
        watch(1, 8, 8);
        check("lsb_idle_after", sval_l, 0);

        // Back-to-back 0xA5 then 0x3C with load_valid held
        push_seq(0, 16'b1010_0101, 8, 1);
        push_seq(0, 16'b0011_1100, 8, 1);
        lv_m = 1'b1; ld_m = 8'hA5;
        tick();
        ld_m = 8'h3C;
        watch(0, 8, 8);
        lv_m = 1'b0;
        watch(0, 8, 8);
        check("b2b_idle_after", sval_m, 0);

        // Load attempt while busy: 0xFF waits for the last bit of a 0x00 frame
        push_seq(0, 16'b0000_0000, 8, 1);
        push_seq(0, 16'b1111_1111, 8, 1);
        lv_m = 1'b1; ld_m = 8'h00;
        tick();
        lv_m = 1'b0;
        watch(0, 1, 0);
        lv_m = 1'b1; ld_m = 8'hFF;
        watch(0, 7, 7);
        lv_m = 1'b0;
        watch(0, 8, 8);
        check("busy_idle_after", sval_m, 0);

        // Reset at bit 4 of 0xA5, then a fresh 0x81 frame
        push_seq(0, 16'b0000_1010, 4, 0);
        lv_m = 1'b1; ld_m = 8'hA5;
        tick();
        lv_m = 1'b0;
        watch(0, 3, 0);
        rst = 1'b1;
        #1;
        check("mid_reset_ready", rdy_m, 0);
        tick();
        rst = 1'b0;
        #1;
        check("abort_valid", sval_m, 0);
        check("abort_sout", sout_m, 0);
        check("abort_last", slast_m, 0);
        push_seq(0, 16'b1000_0001, 8, 1);
        lv_m = 1'b1; ld_m = 8'h81;
        tick();
        lv_m = 1'b0;
        watch(0, 8, 8);
        check("post_reset_idle", sval_m, 0);

        tick();
        check("m_queue_drained", exp_m.size(), 0);
        check("l_queue_drained", exp_l.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
Parallel-in/serial-out transmitter. It accepts a WIDTH-bit word over a valid/ready handshake and drives it one bit per clock onto a serial line, with a per-bit valid and a last-bit marker. It is the sending end for the team's serial-in shift-register receivers. It supports gapless back-to-back frames.

Parameters:
WIDTH, 8, word length in bits; legal range 2..32.
MSB_FIRST, 1, 1 = bit WIDTH-1 transmitted first; 0 = bit 0 transmitted first.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  reset, synchronous, active-high.
load_valid  input  1  load_data is valid this cycle.
load_ready  output  1  block can accept a word this cycle.
load_data  input  WIDTH  parallel word to transmit.
sout  output  1  serial data bit.
sout_valid  output  1  sout carries a frame bit this cycle.
sout_last  output  1  current sout is the final bit of the frame.
busy  output  1  frame in progress; equals sout_valid.

Behaviour:
- State: FSM {IDLE, SHIFT}, WIDTH-bit shift register sreg, bit counter cnt of width clog2(WIDTH).
- rst high at a clock edge puts the block in the reset state:
  - state=IDLE, sreg=0, cnt=0.
  - Next cycle: sout=0, sout_valid=0, sout_last=0, busy=0.
  - rst has priority over any handshake in the same cycle.
- load_ready (combinational):
  - 0 while rst=1.
  - Otherwise 1 in IDLE, or in SHIFT when cnt==0 (last-bit cycle).
  - Otherwise 0.
- Accept = load_valid & load_ready at a clock edge:
  - sreg <= load_data, cnt <= WIDTH-1, state <= SHIFT.
  - load_data is sampled only on accept; changes at other times are ignored.
- Latency: first frame bit appears on sout in the cycle immediately after the accept edge.
- Output decode (combinational from registers, glitch-free relative to clk):
  - sout = sreg[WIDTH-1] if MSB_FIRST, else sreg[0], when state=SHIFT; 0 in IDLE.
  - sout_valid = busy = (state==SHIFT).
  - sout_last = (state==SHIFT) & (cnt==0).
- In SHIFT with cnt!=0:
  - MSB_FIRST=1: sreg <= {sreg[WIDTH-2:0],1'b0}.
  - MSB_FIRST=0: sreg <= {1'b0,sreg[WIDTH-1:1]}.
  - cnt <= cnt-1.
- In SHIFT with cnt==0:
  - Accept in the same cycle: reload as above and stay in SHIFT (zero-gap next frame).
  - No accept: state <= IDLE, sreg <= 0.
- Each frame is exactly WIDTH consecutive cycles of sout_valid=1; sout_last is high on exactly one of them.
- load_valid in SHIFT with cnt!=0: not accepted (load_ready=0). The upstream holds data until accepted.
- Reset mid-frame: frame aborted with no partial continuation. sout_valid=0 from the cycle after the rst edge. The first post-reset accept starts a fresh full frame.
- No counter wrap: cnt never decrements below 0, and cnt is never loaded with a value other than WIDTH-1.

Test Plan:
- Reset, then idle. WIDTH=8: hold rst 2 cycles with load_valid=1 -> no accept. After release, sout=0, sout_valid=0, load_ready=1.
- Single frame. MSB_FIRST=1, accept 0x0F at edge T:
  - cycles T+1..T+8: sout=0,0,0,0,1,1,1,1; sout_valid=1.
  - sout_last=1 only at T+8.
  - idle at T+9.
- LSB-first. MSB_FIRST=0, accept 0xC1 -> sout=1,0,0,0,0,0,1,1 over 8 cycles; sout_last on the 8th.
- Back-to-back. MSB_FIRST=1, load_valid held, words 0xA5 then 0x3C:
  - 16 consecutive valid cycles: 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0.
  - load_ready=1 only at the accept cycle and the 8th bit.
  - sout_last at bits 8 and 16.
- Busy-load ignore. Present 0xFF with load_valid during bits 2..7 of a 0x00 frame:
  - load_ready=0 throughout, and the 0x00 frame bits stay 0.
  - 0xFF is accepted at the last-bit cycle and follows gaplessly.
- Reset mid-frame. Assert rst 1 cycle at bit 4 of 0xA5:
  - sout_valid=0 the next cycle.
  - A new accept of 0x81 yields a full 1,0,0,0,0,0,0,1.
